// File: rtl/signature_sequencer_pkg.sv
// Shared types and constants for the signature sequencer slice.
// Optional feature macro used elsewhere in this slice: SIG_COMPARE_EN.
package signature_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    RESP
  } state_t;

  // Seed loaded into the signature counter by each load pulse, and its width.
  localparam logic [7:0]  SIG_SEED = 8'h55;
  localparam int unsigned SIG_W    = 8;

  // Saturate a requested burst length at the collector width.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned maxlen);
    return (len > maxlen) ? maxlen : len;
  endfunction

endpackage

// File: rtl/signature_sequencer_if.sv
// Request/response bundle between test-control logic and the signature sequencer.
// With SIG_COMPARE_EN defined, it also carries golden words and the match flag.
interface signature_sequencer_if #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned MAXLEN = 16
);
  localparam int unsigned LENW = $clog2(MAXLEN + 1);
  localparam int unsigned IDW  = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*LENW-1:0] req_len;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [MAXLEN-1:0]    rsp_sig;
`ifdef SIG_COMPARE_EN
  logic [NREQ*MAXLEN-1:0] req_golden;
  logic                   rsp_match;

  modport master (
    output req_valid, req_len, rsp_ready, req_golden,
    input  req_ready, rsp_valid, rsp_id, rsp_sig, rsp_match
  );
  modport slave (
    input  req_valid, req_len, rsp_ready, req_golden,
    output req_ready, rsp_valid, rsp_id, rsp_sig, rsp_match
  );
`else
  modport master (
    output req_valid, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sig
  );
  modport slave (
    input  req_valid, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sig
  );
`endif

endinterface

// File: rtl/signature_sequencer_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the
// winner whenever a grant is taken.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_accept,
  output logic            o_any,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_id
);

  logic [IDW-1:0] r_ptr;
  int unsigned    w_idx;

  // Pick the first active request at or after the pointer, wrapping around.
  always_comb begin
    o_any   = 1'b0;
    o_grant = '0;
    o_id    = '0;
    w_idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_idx = (32'(r_ptr) + i) % NREQ;
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_id           = IDW'(w_idx);
      end
    end
  end

  // Pointer advances to the requester after the winner on each taken grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_accept && o_any) begin
      r_ptr <= IDW'((32'(o_id) + 1) % NREQ);
    end
  end

endmodule

// File: rtl/signature_sequencer.sv
// Shares one signature generator among NREQ requesters: per granted request
// it issues a load pulse, LEN enable cycles, collects the serial q stream and
// returns it with the requester id. Optional macro: SIG_COMPARE_EN adds a
// per-request golden word and a match flag on the response.
module signature_sequencer
  import signature_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned MAXLEN = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  signature_sequencer_if.slave bus,
  output logic                 busy,
  output logic                 sig_ld,
  output logic                 sig_en,
  input  logic                 sig_q
);

  localparam int unsigned LENW = $clog2(MAXLEN + 1);
  localparam int unsigned IDW  = $clog2(NREQ);

  state_t            r_state;
  state_t            w_next;
  logic [IDW-1:0]    r_id;
  logic [LENW-1:0]   r_cnt;
  logic [MAXLEN-1:0] r_sig;
  logic              r_en_d;

  logic              w_any;
  logic [NREQ-1:0]   w_gnt;
  logic [IDW-1:0]    w_gnt_id;
  logic              w_grant;
  logic [NREQ-1:0]   w_req_ready;
  logic [LENW-1:0]   w_len_raw;
  logic [LENW-1:0]   w_len;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_req    (bus.req_valid),
    .i_accept (w_grant),
    .o_any    (w_any),
    .o_grant  (w_gnt),
    .o_id     (w_gnt_id)
  );

  assign w_len_raw = bus.req_len[32'(w_gnt_id)*LENW +: LENW];
  assign w_len     = LENW'(clamp_len(32'(w_len_raw), MAXLEN));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and strobes; grants are suppressed while reset is held so
  // that no ready pulse is shown for a grant that cannot be taken.
  always_comb begin
    w_next      = r_state;
    w_grant     = 1'b0;
    w_req_ready = '0;
    sig_ld      = 1'b0;
    sig_en      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any && !reset) begin
          w_grant     = 1'b1;
          w_req_ready = w_gnt;
          w_next      = LOAD;
        end
      end
      LOAD: begin
        sig_ld = 1'b1;
        w_next = (r_cnt == '0) ? RESP : RUN;
      end
      RUN: begin
        sig_en = 1'b1;
        if (r_cnt == LENW'(1)) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        w_next = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Burst bookkeeping: latch id/length at grant, count RUN cycles down, and
  // shift q in one cycle behind the enable that produced it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_id   <= '0;
      r_cnt  <= '0;
      r_sig  <= '0;
      r_en_d <= 1'b0;
    end else begin
      r_en_d <= sig_en;
      if (w_grant) begin
        r_id  <= w_gnt_id;
        r_cnt <= w_len;
        r_sig <= '0;
      end else begin
        if (r_state == RUN) begin
          r_cnt <= r_cnt - LENW'(1);
        end
        if (r_en_d) begin
          r_sig <= {r_sig[MAXLEN-2:0], sig_q};
        end
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_sig   = r_sig;
  assign busy          = (r_state != IDLE);

`ifdef SIG_COMPARE_EN
  logic [MAXLEN-1:0] r_gold;

  // Golden word belongs to the granted requester and is frozen at grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gold <= '0;
    end else if (w_grant) begin
      r_gold <= bus.req_golden[32'(w_gnt_id)*MAXLEN +: MAXLEN];
    end
  end

  assign bus.rsp_match = (r_state == RESP) && (r_sig == r_gold);
`endif

endmodule

// File: tb/tb_signature_sequencer.sv
// Self-checking bench for signature_sequencer (default build; extra checks
// when SIG_COMPARE_EN is defined). Includes a behavioural signature generator:
// load sets counter=SIG_SEED, q=0; each enable outputs parity of the counter
// and increments it.
module tb_signature_sequencer;
  import signature_pkg::*;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned MAXLEN = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, sig_ld, sig_en, sig_q;
  logic [SIG_W-1:0] gen_cnt;

  int unsigned cyc = 0;
  int unsigned nchk = 0;
  int unsigned nerr = 0;
  int unsigned overlap = 0;
  int unsigned ptr_model = 0;

  signature_sequencer_if #(.NREQ(NREQ), .MAXLEN(MAXLEN)) bus ();

  signature_sequencer #(.NREQ(NREQ), .MAXLEN(MAXLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .busy   (busy),
    .sig_ld (sig_ld),
    .sig_en (sig_en),
    .sig_q  (sig_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (sig_ld && sig_en) overlap <= overlap + 1;

  always @(posedge clk) begin
    if (reset || sig_ld) begin
      gen_cnt <= SIG_SEED;
      sig_q   <= 1'b0;
    end else if (sig_en) begin
      gen_cnt <= gen_cnt + 1'b1;
      sig_q   <= ^gen_cnt;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", nchk, nerr);
    $fatal(1);
  end

  // Expected word: k-th collected bit is parity(SIG_SEED+k), first bit in MSB.
  function automatic logic [MAXLEN-1:0] model_sig(input int unsigned len);
    logic [MAXLEN-1:0] s;
    logic [7:0] c;
    s = '0;
    for (int unsigned k = 0; k < len; k++) begin
      c = SIG_SEED + 8'(k);
      s[len-1-k] = ^c;
    end
    return s;
  endfunction

  function automatic int unsigned min_len(input int unsigned l);
    return (l > MAXLEN) ? MAXLEN : l;
  endfunction

  function automatic int unsigned model_winner(input logic [NREQ-1:0] mask, input int unsigned ptr);
    for (int unsigned i = 0; i < NREQ; i++)
      if (mask[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_len   = '0;
    bus.rsp_ready = 1'b0;
`ifdef SIG_COMPARE_EN
    bus.req_golden = '0;
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ptr_model = 0;
  endtask

  task automatic wait_grant(input string tag);
    int unsigned t;
    t = 0;
    @(negedge clk);
    while (bus.req_ready == '0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " grant timeout"}, 32'(bus.req_ready == '0), 32'(0));
  endtask

  task automatic wait_rsp(input string tag);
    int unsigned t;
    t = 0;
    @(negedge clk);
    while (!bus.rsp_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " rsp timeout"}, 32'(!bus.rsp_valid), 32'(0));
  endtask

  // Results of the most recent burst().
  logic [NREQ-1:0]   res_gnt;
  logic [MAXLEN-1:0] res_sig;
  int unsigned       res_lat, res_nld, res_nen, res_id;
  logic              res_stable, res_idle_ok;
`ifdef SIG_COMPARE_EN
  logic              res_match;
`endif

  // One complete transaction: request, grant, burst, optional back-pressure, accept.
  task automatic burst(input logic [NREQ-1:0] mask, input int unsigned l0, input int unsigned l1,
                       input int unsigned hold);
    int unsigned t, gcyc;
    res_gnt = '0; res_sig = '0; res_lat = 0; res_nld = 0; res_nen = 0; res_id = 0;
    res_stable = 1'b1; res_idle_ok = 1'b0;
`ifdef SIG_COMPARE_EN
    res_match = 1'b0;
`endif
    @(posedge clk); #1;
    bus.req_valid = mask;
    bus.req_len   = {5'(l1), 5'(l0)};
    t = 0;
    @(negedge clk);
    while (bus.req_ready == '0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    res_gnt = bus.req_ready;
    gcyc = cyc;
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.req_len   = '1;
    if (res_gnt == '0) return;
    t = 0;
    @(negedge clk);
    while (!bus.rsp_valid && t < 40) begin
      if (sig_ld) res_nld++;
      if (sig_en) res_nen++;
      @(negedge clk);
      t++;
    end
    if (!bus.rsp_valid) return;
    res_lat = cyc - gcyc;
    res_id  = 32'(bus.rsp_id);
    res_sig = bus.rsp_sig;
`ifdef SIG_COMPARE_EN
    res_match = bus.rsp_match;
`endif
    for (int unsigned h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!bus.rsp_valid || 32'(bus.rsp_id) != res_id || bus.rsp_sig != res_sig ||
          bus.req_ready != '0 || sig_en || sig_ld)
        res_stable = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    res_idle_ok = !busy && !bus.rsp_valid;
`ifdef SIG_COMPARE_EN
    if (bus.rsp_match) res_idle_ok = 1'b0;
`endif
  endtask

  typedef struct {
    logic [NREQ-1:0]   mask;
    int unsigned       l0, l1, hold;
    logic [MAXLEN-1:0] gold;
    int unsigned       exp_w;
    logic [MAXLEN-1:0] exp_sig;
    int unsigned       exp_lat, exp_nen;
  } vec_t;

  vec_t vecs[7];
  int unsigned rr_exp[4];

  initial begin
    string tag;
    int unsigned w, l0, l1, len, hold;
    logic [NREQ-1:0] mask;

    // mask, l0, l1, hold, golden, winner, rsp_sig, latency, enables
    vecs[0] = '{2'b01,  8,  0, 0, 16'h0032, 0, 16'h0032, 11,  8};
    vecs[1] = '{2'b10,  0,  4, 5, 16'h0003, 1, 16'h0003,  7,  4};
    vecs[2] = '{2'b01,  0,  0, 1, 16'h0000, 0, 16'h0000,  2,  0};
    vecs[3] = '{2'b11,  3,  1, 1, 16'h0000, 1, 16'h0000,  4,  1};
    vecs[4] = '{2'b11,  4,  8, 2, 16'h0003, 0, 16'h0003,  7,  4};
    vecs[5] = '{2'b10,  0, 20, 1, 16'h32CD, 1, 16'h32CD, 19, 16};
    vecs[6] = '{2'b01,  8,  0, 0, 16'h0033, 0, 16'h0032, 11,  8};
    rr_exp = '{0, 1, 0, 1};

    // Reset state, with requests pending while reset is held.
    bus.req_valid = '0; bus.req_len = '0; bus.rsp_ready = 1'b0;
`ifdef SIG_COMPARE_EN
    bus.req_golden = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = 2'b11;
    bus.req_len   = {5'd3, 5'd3};
    @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 0);
    chk("reset req_ready", 32'(bus.req_ready), 0);
    chk("reset sig_ld", 32'(sig_ld), 0);
    chk("reset sig_en", 32'(sig_en), 0);
    chk("reset rsp_sig", 32'(bus.rsp_sig), 0);
    chk("reset rsp_id", 32'(bus.rsp_id), 0);
`ifdef SIG_COMPARE_EN
    chk("reset rsp_match", 32'(bus.rsp_match), 0);
`endif

    // Table-driven transactions.
    do_reset();
    for (int unsigned v = 0; v < 7; v++) begin
`ifdef SIG_COMPARE_EN
      bus.req_golden = {vecs[v].gold, vecs[v].gold};
`endif
      burst(vecs[v].mask, vecs[v].l0, vecs[v].l1, vecs[v].hold);
      tag = $sformatf("vec%0d", v);
      chk({tag, " grant"}, 32'(res_gnt), 32'(1) << vecs[v].exp_w);
      chk({tag, " rsp_id"}, res_id, vecs[v].exp_w);
      chk({tag, " rsp_sig"}, 32'(res_sig), 32'(vecs[v].exp_sig));
      chk({tag, " latency"}, res_lat, vecs[v].exp_lat);
      chk({tag, " ld cycles"}, res_nld, 1);
      chk({tag, " en cycles"}, res_nen, vecs[v].exp_nen);
      chk({tag, " stable"}, 32'(res_stable), 1);
      chk({tag, " idle"}, 32'(res_idle_ok), 1);
`ifdef SIG_COMPARE_EN
      chk({tag, " rsp_match"}, 32'(res_match), 32'(vecs[v].gold == vecs[v].exp_sig));
`endif
    end

    // Both requesters held valid, len=2: grants alternate starting at 0.
    do_reset();
    @(posedge clk); #1;
    bus.req_len   = {5'd2, 5'd2};
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      tag = $sformatf("rr%0d", k);
      wait_grant(tag);
      chk({tag, " grant"}, 32'(bus.req_ready), 32'(1) << rr_exp[k]);
      wait_rsp(tag);
      chk({tag, " rsp_id"}, 32'(bus.rsp_id), rr_exp[k]);
      chk({tag, " rsp_sig"}, 32'(bus.rsp_sig), 0);
      chk({tag, " no grant in handshake"}, 32'(bus.req_ready), 0);
      if (k == 3) bus.req_valid = '0;
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;

    // Back-pressure with a second requester waiting.
    do_reset();
    @(posedge clk); #1;
    bus.req_valid = 2'b01;
    bus.req_len   = {5'd0, 5'd8};
    wait_grant("bp");
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp("bp");
    bus.req_valid = 2'b10;
    for (int unsigned h = 0; h < 5; h++) begin
      @(negedge clk);
      chk("bp hold rsp_valid", 32'(bus.rsp_valid), 1);
      chk("bp hold rsp_id", 32'(bus.rsp_id), 0);
      chk("bp hold rsp_sig", 32'(bus.rsp_sig), 32'h0032);
      chk("bp hold req_ready", 32'(bus.req_ready), 0);
      chk("bp hold sig_en", 32'(sig_en), 0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp handshake req_ready", 32'(bus.req_ready), 0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp next grant", 32'(bus.req_ready), 32'b10);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp("bp2");
    chk("bp2 rsp_id", 32'(bus.rsp_id), 1);
    chk("bp2 rsp_sig", 32'(bus.rsp_sig), 0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;

    // Reset in the third RUN cycle drops the burst.
    do_reset();
    @(posedge clk); #1;
    bus.req_valid = 2'b01;
    bus.req_len   = {5'd0, 5'd8};
    wait_grant("rst");
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst run3 sig_en", 32'(sig_en), 1);
    @(negedge clk);
    chk("rst busy", 32'(busy), 0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst sig_en", 32'(sig_en), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ptr_model = 0;
    burst(2'b01, 8, 0, 1);
    chk("rst fresh grant", 32'(res_gnt), 32'b01);
    chk("rst fresh rsp_sig", 32'(res_sig), 32'h0032);
    chk("rst fresh latency", res_lat, 11);
    ptr_model = 1;

    // Randomised transactions against the reference model.
    for (int unsigned it = 0; it < 40; it++) begin
      mask = NREQ'($urandom_range(1, 3));
      l0   = $urandom_range(0, 20);
      l1   = $urandom_range(0, 20);
      hold = $urandom_range(0, 3);
      w    = model_winner(mask, ptr_model);
      len  = min_len((w == 0) ? l0 : l1);
`ifdef SIG_COMPARE_EN
      bus.req_golden = {model_sig(min_len(l1)), model_sig(min_len(l0))};
`endif
      burst(mask, l0, l1, hold);
      tag = $sformatf("rnd%0d", it);
      chk({tag, " grant"}, 32'(res_gnt), 32'(1) << w);
      chk({tag, " rsp_id"}, res_id, w);
      chk({tag, " rsp_sig"}, 32'(res_sig), 32'(model_sig(len)));
      chk({tag, " latency"}, res_lat, (len == 0) ? 2 : len + 3);
      chk({tag, " ld cycles"}, res_nld, 1);
      chk({tag, " en cycles"}, res_nen, len);
      chk({tag, " stable"}, 32'(res_stable), 1);
      chk({tag, " idle"}, 32'(res_idle_ok), 1);
`ifdef SIG_COMPARE_EN
      chk({tag, " rsp_match"}, 32'(res_match), 1);
`endif
      ptr_model = (w + 1) % NREQ;
    end

    chk("ld/en overlap cycles", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
